// File: rtl/banyan_acq_sequencer.sv
// banyan_acq_sequencer: steps a host-programmed list of banyan masks through
// settle -> trigger -> capture -> readout handshake in the adc_clk domain.
module banyan_acq_sequencer #(
    parameter int n_mask = 4,
    parameter int tw     = 24
) (
    input  logic                  adc_clk,
    input  logic                  reset,
    input  logic [8*n_mask-1:0]   mask_list,
    input  logic [2:0]            n_active,
    input  logic                  continuous,
    input  logic [7:0]            settle_cycles,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  readout_done,
    input  logic                  full,
    output logic [7:0]            banyan_mask,
    output logic                  trig,
    output logic [2:0]            slot,
    output logic [2:0]            state,
    output logic                  busy,
    output logic                  data_ready,
    output logic                  error,
    output logic [15:0]           sweep_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_TRIG    = 3'd2,
        S_CAPTURE = 3'd3,
        S_READY   = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    // Timeout fires when the counter is about to reach 2^tw-1.
    localparam logic [tw-1:0] TMO_LAST = {{(tw-1){1'b1}}, 1'b0};
    localparam logic [3:0]    N_MASK4  = 4'(n_mask);

    state_t          r_state;
    logic [2:0]      r_slot;
    logic [7:0]      r_mask;
    logic            r_trig;
    logic [7:0]      r_settle;
    logic [tw-1:0]   r_tmo;
    logic [1:0]      r_guard;
    logic            r_err;
    logic [15:0]     r_sweep;
    logic            r_busy;
    logic            r_ready;

    logic [3:0]      w_n_eff;
    logic            w_more;
    logic [2:0]      w_next_slot;
    logic [7:0]      w_next_mask;
    logic [7:0]      w_mask0;

    // Effective slot count: 0 means one slot, anything above n_mask is clamped.
    always_comb begin
        w_n_eff = {1'b0, n_active};
        if (n_active == 3'd0) begin
            w_n_eff = 4'd1;
        end else if ({1'b0, n_active} > N_MASK4) begin
            w_n_eff = N_MASK4;
        end
    end

    // A slot index at or past the last effective slot ends the sweep, so a
    // mid-sweep shrink of n_active cannot walk past the mask list.
    assign w_more      = ({1'b0, r_slot} + 4'd1) < w_n_eff;
    assign w_next_slot = r_slot + 3'd1;
    assign w_next_mask = mask_list[8*int'(w_next_slot) +: 8];
    assign w_mask0     = mask_list[7:0];

    // Sequencer FSM; all outputs are registered alongside the state.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_slot   <= '0;
            r_mask   <= '0;
            r_trig   <= 1'b0;
            r_settle <= '0;
            r_tmo    <= '0;
            r_guard  <= '0;
            r_err    <= 1'b0;
            r_sweep  <= '0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_trig  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        r_slot   <= '0;
                        r_mask   <= w_mask0;
                        r_settle <= settle_cycles;
                        r_err    <= 1'b0;
                        r_state  <= S_SETTLE;
                        r_busy   <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == 8'd0) begin
                        r_state <= S_TRIG;
                        r_trig  <= 1'b1;
                    end else begin
                        r_settle <= r_settle - 8'd1;
                    end
                end
                S_TRIG: begin
                    r_tmo   <= '0;
                    r_guard <= '0;
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (r_guard != 2'd2) begin
                        r_guard <= r_guard + 2'd1;
                    end
                    if (r_guard == 2'd2 && full) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end else if (r_tmo == TMO_LAST) begin
                        r_state <= S_ERROR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_READY: begin
                    if (readout_done) begin
                        r_ready <= 1'b0;
                        if (w_more) begin
                            r_slot   <= w_next_slot;
                            r_mask   <= w_next_mask;
                            r_settle <= settle_cycles;
                            r_state  <= S_SETTLE;
                        end else begin
                            r_sweep <= r_sweep + 16'd1;
                            if (continuous) begin
                                r_slot   <= '0;
                                r_mask   <= w_mask0;
                                r_settle <= settle_cycles;
                                r_state  <= S_SETTLE;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign banyan_mask = r_mask;
    assign trig        = r_trig;
    assign slot        = r_slot;
    assign state       = r_state;
    assign busy        = r_busy;
    assign data_ready  = r_ready;
    assign error       = r_err;
    assign sweep_count = r_sweep;

endmodule
